// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // x0 is hardwired to zero, so it never produces a hazard or a forward.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: decode/EX/MEM status in, stall/flush/forward controls out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  import core_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_is_branch;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic                  ex_br_valid;
  logic                  ex_br_taken;

  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  id_ex_bubble;
  logic                  if_id_flush;
  logic                  pc_redirect;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  br_timeout_err;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_is_branch, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_br_valid, ex_br_taken,
    input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pc_redirect,
           fwd_a_sel, fwd_b_sel, br_timeout_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_is_branch, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_br_valid, ex_br_taken,
    output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pc_redirect,
           fwd_a_sel, fwd_b_sel, br_timeout_err, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding source select for one EX operand; EX producers beat MEM producers, loads never forward from EX.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  output logic [1:0]            sel
);

  // Priority compare of the decode source against EX then MEM destinations.
  always_comb begin
    sel = FWD_REG;
    if (ex_reg_write && !ex_mem_read && reg_hit(ex_rd, rs)) begin
      sel = FWD_MEM;
    end else if (mem_reg_write && reg_hit(mem_rd, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch hold/squash/redirect sequencing, EX-aligned forwarding selects and stall counter.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int BR_TIMEOUT = 4,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int TMO_W = $clog2(BR_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BR_TIMEOUT - 1);

  state_e           state_r, state_nxt_s;
  logic [TMO_W-1:0] tmo_r, tmo_nxt_s;
  logic             lu_s, set_err_s;
  logic             pc_stall_s, if_id_stall_s, bubble_s, flush_s, redirect_s;
  logic [1:0]       fwd_a_s, fwd_b_s, fwd_a_r, fwd_b_r;
  logic             err_r;
  logic [CNT_W-1:0] stall_cnt_r;

  // Load in EX whose result a decode source needs.
  always_comb begin
    lu_s = hz.id_valid && hz.ex_mem_read &&
           (reg_hit(hz.ex_rd, hz.id_rs1) || reg_hit(hz.ex_rd, hz.id_rs2));
  end

  // Mealy control outputs and next-state; everything idles while reset is held.
  always_comb begin
    pc_stall_s    = 1'b0;
    if_id_stall_s = 1'b0;
    bubble_s      = 1'b0;
    flush_s       = 1'b0;
    redirect_s    = 1'b0;
    set_err_s     = 1'b0;
    state_nxt_s   = state_r;
    tmo_nxt_s     = tmo_r;
    if (!rst_n) begin
      state_nxt_s = RUN;
      tmo_nxt_s   = '0;
    end else begin
      case (state_r)
        RUN: begin
          tmo_nxt_s = '0;
          if (lu_s) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            bubble_s      = 1'b1;
          end else if (hz.id_valid && hz.id_is_branch) begin
            state_nxt_s = BR_WAIT;
          end else begin
            state_nxt_s = RUN;
          end
        end
        BR_WAIT: begin
          pc_stall_s = 1'b1;
          flush_s    = 1'b1;
          if (hz.ex_br_valid) begin
            redirect_s  = hz.ex_br_taken;
            state_nxt_s = RUN;
            tmo_nxt_s   = '0;
          end else if (tmo_r == TMO_LAST) begin
            set_err_s   = 1'b1;
            state_nxt_s = RUN;
            tmo_nxt_s   = '0;
          end else begin
            tmo_nxt_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nxt_s = RUN;
          tmo_nxt_s   = '0;
        end
      endcase
    end
  end

  fwd_unit u_fwd_a (
    .rs(hz.id_rs1), .ex_rd(hz.ex_rd), .ex_reg_write(hz.ex_reg_write),
    .ex_mem_read(hz.ex_mem_read), .mem_rd(hz.mem_rd), .mem_reg_write(hz.mem_reg_write),
    .sel(fwd_a_s)
  );

  fwd_unit u_fwd_b (
    .rs(hz.id_rs2), .ex_rd(hz.ex_rd), .ex_reg_write(hz.ex_reg_write),
    .ex_mem_read(hz.ex_mem_read), .mem_rd(hz.mem_rd), .mem_reg_write(hz.mem_reg_write),
    .sel(fwd_b_s)
  );

  // State, timeout counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    state_r <= state_nxt_s;
    tmo_r   <= tmo_nxt_s;
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (set_err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Forward selects follow the instruction into EX; a bubble or squashed slot carries no forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_r <= FWD_REG;
      fwd_b_r <= FWD_REG;
    end else if (bubble_s || (state_r == BR_WAIT) || !hz.id_valid) begin
      fwd_a_r <= FWD_REG;
      fwd_b_r <= FWD_REG;
    end else if (if_id_stall_s) begin
      fwd_a_r <= fwd_a_r;
      fwd_b_r <= fwd_b_r;
    end else begin
      fwd_a_r <= fwd_a_s;
      fwd_b_r <= fwd_b_s;
    end
  end

  // Saturating count of PC-stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (pc_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.pc_stall       = pc_stall_s;
  assign hz.if_id_stall    = if_id_stall_s;
  assign hz.id_ex_bubble   = bubble_s;
  assign hz.if_id_flush    = flush_s;
  assign hz.pc_redirect    = redirect_s;
  assign hz.fwd_a_sel      = fwd_a_r;
  assign hz.fwd_b_sel      = fwd_b_r;
  assign hz.br_timeout_err = err_r;
  assign hz.stall_cnt      = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus random stimulus for hazard_ctrl, checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int BR_TIMEOUT = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  // model state: branch pending, cycles spent waiting, sticky error, stall count, EX-aligned selects
  bit m_br;
  int m_wait;
  bit m_err;
  int m_cnt;
  int m_fa;
  int m_fb;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.BR_TIMEOUT(BR_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fwd_src(input int rs);
    if (hz.ex_reg_write && !hz.ex_mem_read && hz.ex_rd != 0 && int'(hz.ex_rd) == rs) return 2;
    if (hz.mem_reg_write && hz.mem_rd != 0 && int'(hz.mem_rd) == rs) return 1;
    return 0;
  endfunction

  task automatic set_in(input bit v, input int rs1, input int rs2, input bit br,
                        input int erd, input bit ewr, input bit eld,
                        input int mrd, input bit mwr, input bit bv, input bit bt);
    hz.id_valid      = v;
    hz.id_rs1        = 5'(rs1);
    hz.id_rs2        = 5'(rs2);
    hz.id_is_branch  = br;
    hz.ex_rd         = 5'(erd);
    hz.ex_reg_write  = ewr;
    hz.ex_mem_read   = eld;
    hz.mem_rd        = 5'(mrd);
    hz.mem_reg_write = mwr;
    hz.ex_br_valid   = bv;
    hz.ex_br_taken   = bt;
  endtask

  // Check every output against the model for the current inputs, then advance one clock.
  task automatic tick();
    bit lu, e_stall, e_ifid, e_bub, e_fl, e_rd;
    lu = hz.id_valid && hz.ex_mem_read && hz.ex_rd != 0 &&
         (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
    e_stall = 0; e_ifid = 0; e_bub = 0; e_fl = 0; e_rd = 0;
    if (rst_n) begin
      if (m_br) begin
        e_stall = 1; e_fl = 1; e_rd = hz.ex_br_valid && hz.ex_br_taken;
      end else if (lu) begin
        e_stall = 1; e_ifid = 1; e_bub = 1;
      end
    end
    #3;
    chk("pc_stall",       hz.pc_stall,       e_stall);
    chk("if_id_stall",    hz.if_id_stall,    e_ifid);
    chk("id_ex_bubble",   hz.id_ex_bubble,   e_bub);
    chk("if_id_flush",    hz.if_id_flush,    e_fl);
    chk("pc_redirect",    hz.pc_redirect,    e_rd);
    chk("fwd_a_sel",      hz.fwd_a_sel,      m_fa);
    chk("fwd_b_sel",      hz.fwd_b_sel,      m_fb);
    chk("br_timeout_err", hz.br_timeout_err, m_err);
    chk("stall_cnt",      hz.stall_cnt,      m_cnt);
    @(posedge clk);
    if (!rst_n) begin
      m_br = 0; m_wait = 0; m_err = 0; m_cnt = 0; m_fa = 0; m_fb = 0;
    end else begin
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      if (e_bub || m_br || !hz.id_valid) begin
        m_fa = 0; m_fb = 0;
      end else if (!e_ifid) begin
        m_fa = fwd_src(int'(hz.id_rs1));
        m_fb = fwd_src(int'(hz.id_rs2));
      end
      if (m_br) begin
        m_wait++;
        if (hz.ex_br_valid) begin
          m_br = 0; m_wait = 0;
        end else if (m_wait >= BR_TIMEOUT) begin
          m_err = 1; m_br = 0; m_wait = 0;
        end
      end else if (!lu && hz.id_valid && hz.id_is_branch) begin
        m_br = 1; m_wait = 0;
      end
    end
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    m_br = 0; m_wait = 0; m_err = 0; m_cnt = 0; m_fa = 0; m_fb = 0;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    tick(); tick();
    rst_n = 1'b1;

    // load x5 in EX, decode reads x5: one bubble, then the load sits in MEM
    set_in(1, 5, 9, 0, 5, 1, 1, 0, 0, 0, 0);
    tick();
    chk("lu_fwd_a_zero", hz.fwd_a_sel, 0);
    chk("lu_cnt_one",    hz.stall_cnt, 1);
    set_in(1, 5, 9, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    chk("lu_then_wb", hz.fwd_a_sel, 1);

    // x7 in both EX and MEM: EX wins; with EX rd=0 MEM forwards
    set_in(1, 3, 7, 0, 7, 1, 0, 7, 1, 0, 0);
    tick();
    chk("fwd_b_ex_prio", hz.fwd_b_sel, 2);
    set_in(1, 3, 7, 0, 0, 1, 0, 7, 1, 0, 0);
    tick();
    chk("fwd_b_mem", hz.fwd_b_sel, 1);

    // branch resolves taken after one wait cycle
    set_in(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("br_redirect", hz.pc_redirect, 1);
    chk("br_flush",    hz.if_id_flush, 1);
    tick();
    set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // branch never resolves: timeout after BR_TIMEOUT wait cycles
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_in(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < BR_TIMEOUT; i++) tick();
    chk("tmo_err", hz.br_timeout_err, 1);
    chk("tmo_cnt", hz.stall_cnt, BR_TIMEOUT);
    tick();

    // load-use together with a branch: bubble first, then branch wait
    set_in(1, 3, 0, 1, 3, 1, 1, 0, 0, 0, 0);
    tick();
    set_in(1, 3, 0, 1, 0, 0, 0, 3, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("lu_br_wait", hz.pc_stall, 1);
    tick();
    // x0 load never stalls
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();

    // reset in the middle of a branch wait drops the branch
    set_in(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // repeated timeouts drive the counter into saturation
    for (int k = 0; k < 5; k++) begin
      set_in(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < BR_TIMEOUT; i++) tick();
    end
    chk("cnt_saturated", hz.stall_cnt, CNT_MAX);

    // random traffic with a small register pool to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      tick();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
